// File: rtl/maxpool_seq.sv
// Streaming max-pool: reduces each 64-lane beat to its maximum via find_max_64,
// then folds cfg_win_len consecutive beat maxima into one held result.

module find_max_64 #(
  parameter int WIDTH = 6,
  parameter int LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_en,
  input  logic [WIDTH*64-1:0]  i_data,
  output logic [WIDTH-1:0]     result
);
  logic [WIDTH-1:0] max_c;
  logic [WIDTH-1:0] stage_q [LAT];

  always_comb begin
    max_c = i_data[WIDTH-1:0];
    for (int k = 1; k < 64; k++) begin
      if (i_data[k*WIDTH +: WIDTH] > max_c) max_c = i_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stage_q[0] <= '0;
    else if (pipe_en) stage_q[0] <= max_c;
  end

  genvar gi;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       stage_q[gi] <= '0;
        else if (pipe_en) stage_q[gi] <= stage_q[gi-1];
      end
    end
  endgenerate

  assign result = stage_q[LAT-1];
endmodule

module maxpool_seq #(
  parameter int WIDTH     = 6,
  parameter int NUM_LANES = 64,
  parameter int PIPE_LAT  = 1,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT_W-1:0]           cfg_win_len,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [WIDTH*NUM_LANES-1:0] i_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [WIDTH-1:0]           o_data,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    o_data_q, o_data_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    win_len_q, win_len_d;
  logic [PIPE_LAT-1:0] tag_q;

  logic             stall, pipe_en, emerge, open_win, last_beat;
  logic [WIDTH-1:0] result, merged;
  logic [CNT_W-1:0] eff_cfg;

  find_max_64 #(.WIDTH(WIDTH), .LAT(PIPE_LAT)) u_find_max (
    .clk     (clk),
    .rst_n   (rst_n),
    .pipe_en (pipe_en),
    .i_data  (i_data),
    .result  (result)
  );

  // Tags travel alongside the data so a frozen pipe neither drops nor repeats beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tag_q <= '0;
    else if (pipe_en) tag_q <= (tag_q << 1) | PIPE_LAT'(i_valid & i_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      o_data_q   <= '0;
      beat_cnt_q <= '0;
      win_len_q  <= CNT_W'(1);
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      o_data_q   <= o_data_d;
      beat_cnt_q <= beat_cnt_d;
      win_len_q  <= win_len_d;
    end
  end

  assign emerge    = tag_q[PIPE_LAT-1] & pipe_en;
  assign eff_cfg   = (cfg_win_len == '0) ? CNT_W'(1) : cfg_win_len;
  assign merged    = (result > acc_q) ? result : acc_q;
  // Extra bit keeps win_len = 2^CNT_W-1 from wrapping the compare.
  assign last_beat = (({1'b0, beat_cnt_q} + (CNT_W+1)'(1)) == {1'b0, win_len_q});

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    o_data_d   = o_data_q;
    beat_cnt_d = beat_cnt_q;
    win_len_d  = win_len_q;
    open_win   = 1'b0;
    case (state_q)
      IDLE:  open_win = emerge;
      ACCUM: begin
        if (emerge) begin
          if (last_beat) begin
            o_data_d   = merged;
            beat_cnt_d = '0;
            state_d    = DONE;
          end else begin
            acc_d      = merged;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (o_ready) begin
          state_d  = IDLE;
          open_win = emerge;
        end
      end
      default: state_d = IDLE;
    endcase
    if (open_win) begin
      win_len_d = eff_cfg;
      acc_d     = result;
      if (eff_cfg == CNT_W'(1)) begin
        o_data_d   = result;
        beat_cnt_d = '0;
        state_d    = DONE;
      end else begin
        beat_cnt_d = CNT_W'(1);
        state_d    = ACCUM;
      end
    end
  end

  always_comb begin
    o_valid = (state_q == DONE);
    stall   = o_valid & ~o_ready;
    pipe_en = ~stall;
    i_ready = ~stall;
    busy    = (|tag_q) | (state_q != IDLE);
    o_data  = o_data_q;
  end
endmodule

// File: tb/tb_maxpool_seq.sv
// Directed bench for maxpool_seq: window table plus latency, backpressure,
// config-change, long-window and mid-window reset sequences.

module tb_maxpool_seq;
  localparam int WIDTH = 6;
  localparam int LANES = 64;
  localparam int CNT_W = 8;
  localparam int DW    = WIDTH * LANES;

  logic             clk, rst_n, i_valid, i_ready, o_valid, o_ready, busy;
  logic [CNT_W-1:0] cfg_win_len;
  logic [DW-1:0]    i_data;
  logic [WIDTH-1:0] o_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] got_q[$];

  maxpool_seq #(.WIDTH(WIDTH), .NUM_LANES(LANES), .PIPE_LAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_win_len(cfg_win_len), .i_valid(i_valid),
    .i_ready(i_ready), .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_data(o_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // o_ready only changes just after a rising edge, so the falling-edge value is what the next edge sees.
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) got_q.push_back(o_data);
  end

  typedef struct packed {
    logic [7:0]            cfg;
    logic [3:0]            nb;
    logic [0:7][WIDTH-1:0] mx;
    logic [2:0]            ne;
    logic [0:3][WIDTH-1:0] ex;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  function automatic logic [DW-1:0] mk_beat(input logic [WIDTH-1:0] m, input int lane, input bit zeros);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!zeros) d[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, int'(m)));
    end
    d[lane*WIDTH +: WIDTH] = m;
    return d;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the beat until accepted; reports how many cycles it was refused.
  task automatic send_beat(input logic [DW-1:0] d, output int stalls);
    stalls = 0;
    i_valid = 1'b1;
    i_data  = d;
    forever begin
      @(negedge clk);
      if (i_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      stalls++;
      if (stalls > 60) begin
        n_fail++;
        $display("FAIL accept_timeout: got %0d cycles required <= 60", stalls);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic check_results(input string nm, input int ne, input logic [0:3][WIDTH-1:0] ex);
    chk({nm, " count"}, got_q.size(), ne);
    for (int k = 0; k < ne && k < got_q.size(); k++)
      chk($sformatf("%s res%0d", nm, k), got_q[k], ex[k]);
    got_q.delete();
  endtask

  vec_t vecs[7];

  initial begin
    int st, tot, held, waited;
    logic [0:3][WIDTH-1:0] ex;

    vecs[0] = {8'd4, 4'd4, {6'd10, 6'd63, 6'd7,  6'd20, 6'd0, 6'd0, 6'd0, 6'd0}, 3'd1, {6'd63, 6'd0,  6'd0, 6'd0}};
    vecs[1] = {8'd1, 4'd1, {6'd5,  6'd0,  6'd0,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0}, 3'd1, {6'd5,  6'd0,  6'd0, 6'd0}};
    vecs[2] = {8'd0, 4'd3, {6'd12, 6'd40, 6'd1,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0}, 3'd3, {6'd12, 6'd40, 6'd1, 6'd0}};
    vecs[3] = {8'd3, 4'd3, {6'd1,  6'd2,  6'd3,  6'd0,  6'd0, 6'd0, 6'd0, 6'd0}, 3'd1, {6'd3,  6'd0,  6'd0, 6'd0}};
    vecs[4] = {8'd2, 4'd4, {6'd0,  6'd0,  6'd63, 6'd62, 6'd0, 6'd0, 6'd0, 6'd0}, 3'd2, {6'd0,  6'd63, 6'd0, 6'd0}};
    vecs[5] = {8'd5, 4'd5, {6'd30, 6'd31, 6'd29, 6'd31, 6'd0, 6'd0, 6'd0, 6'd0}, 3'd1, {6'd31, 6'd0,  6'd0, 6'd0}};
    vecs[6] = {8'd2, 4'd6, {6'd1,  6'd9,  6'd9,  6'd1,  6'd5, 6'd6, 6'd0, 6'd0}, 3'd3, {6'd9,  6'd9,  6'd6, 6'd0}};

    rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b0; cfg_win_len = 8'd1; i_data = '0;
    @(negedge clk);
    chk("reset o_valid", o_valid, 0);
    chk("reset o_data", o_data, 0);
    chk("reset busy", busy, 0);
    chk("reset i_ready", i_ready, 1);
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset i_ready", i_ready, 1);
    cyc(1);

    // Single beat, lane 63 = 45: o_valid two edges after presentation.
    cfg_win_len = 8'd1;
    i_valid = 1'b1; i_data = mk_beat(6'd45, 63, 1'b1);
    cyc(1);
    i_valid = 1'b0;
    @(negedge clk);
    chk("single o_valid at +1", o_valid, 0);
    chk("single busy at +1", busy, 1);
    cyc(1);
    @(negedge clk);
    chk("single o_valid at +2", o_valid, 1);
    chk("single o_data", o_data, 45);
    cyc(1);
    o_ready = 1'b1;
    cyc(2);
    got_q.delete();
    @(negedge clk);
    chk("single o_valid cleared", o_valid, 0);
    cyc(1);

    for (int v = 0; v < 7; v++) begin
      cfg_win_len = vecs[v].cfg;
      tot = 0;
      for (int b = 0; b < int'(vecs[v].nb); b++) begin
        send_beat(mk_beat(vecs[v].mx[b], (b * 13 + v * 5) % LANES, 1'b0), st);
        tot += st;
      end
      cyc(4);
      chk($sformatf("vec%0d stalls", v), tot, 0);
      check_results($sformatf("vec%0d", v), int'(vecs[v].ne), vecs[v].ex);
    end

    // Backpressure: o_ready low while more beats are offered.
    cfg_win_len = 8'd2;
    o_ready = 1'b0;
    fork
      begin
        send_beat(mk_beat(6'd8,  3, 1'b0), st);
        send_beat(mk_beat(6'd3,  9, 1'b0), st);
        send_beat(mk_beat(6'd50, 0, 1'b0), st);
        send_beat(mk_beat(6'd9, 22, 1'b0), st);
        send_beat(mk_beat(6'd2, 40, 1'b0), st);
        send_beat(mk_beat(6'd61, 63, 1'b0), st);
      end
      begin
        waited = 0;
        @(negedge clk);
        while (!o_valid && waited < 50) begin
          @(negedge clk);
          waited++;
        end
        chk("bp o_valid seen", o_valid, 1);
        held = int'(o_data);
        chk("bp first result", held, 8);
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk($sformatf("bp stall%0d i_ready", c), i_ready, 0);
          chk($sformatf("bp stall%0d o_data", c), o_data, held);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;
      end
    join
    cyc(4);
    ex = {6'd8, 6'd50, 6'd61, 6'd0};
    check_results("bp", 3, ex);

    // cfg 3 -> 2 after the first window opened.
    cfg_win_len = 8'd3;
    send_beat(mk_beat(6'd4, 1, 1'b0), st);
    send_beat(mk_beat(6'd9, 2, 1'b0), st);
    cfg_win_len = 8'd2;
    send_beat(mk_beat(6'd1, 3, 1'b0), st);
    send_beat(mk_beat(6'd7, 4, 1'b0), st);
    send_beat(mk_beat(6'd2, 5, 1'b0), st);
    cyc(4);
    ex = {6'd9, 6'd7, 6'd0, 6'd0};
    check_results("cfgchg", 2, ex);

    // Longest window: 255 beats, one result.
    cfg_win_len = 8'd255;
    for (int b = 0; b < 255; b++)
      send_beat(mk_beat((b == 200) ? 6'd50 : WIDTH'(b % 37), b % LANES, 1'b0), st);
    @(negedge clk);
    chk("win255 busy before result", busy, 1);
    cyc(4);
    ex = {6'd50, 6'd0, 6'd0, 6'd0};
    check_results("win255", 1, ex);

    // Reset after 2 of 4 beats.
    cfg_win_len = 8'd4;
    send_beat(mk_beat(6'd60, 7, 1'b0), st);
    send_beat(mk_beat(6'd55, 8, 1'b0), st);
    @(negedge clk);
    chk("midrst busy before", busy, 1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst o_valid", o_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst i_ready", i_ready, 1);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    got_q.delete();
    send_beat(mk_beat(6'd5, 10, 1'b0), st);
    send_beat(mk_beat(6'd6, 11, 1'b0), st);
    send_beat(mk_beat(6'd7, 12, 1'b0), st);
    send_beat(mk_beat(6'd4, 13, 1'b0), st);
    cyc(4);
    ex = {6'd7, 6'd0, 6'd0, 6'd0};
    check_results("midrst", 1, ex);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
